// File: rtl/a_skew_buffer_pkg.sv
// Shared configuration for the activation-edge skew buffer: default sizes,
// activation element/vector types and the stream FSM state encoding.
package a_skew_buffer_pkg;

    localparam int sys_rows           = 2;
    localparam int A_BITWIDTH         = 8;
    localparam int input_buffer_depth = 16;

    typedef logic [A_BITWIDTH-1:0] a_elem_t;
    typedef a_elem_t [sys_rows-1:0] a_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } skew_state_t;

endpackage

// File: rtl/a_skew_buffer_delay.sv
// Fixed-length delay line for one skew lane; data and valid travel together.
// DELAY = 0 degenerates to a plain wire.
module skew_delay_line #(
    parameter int DELAY = 0,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] src_data,
    input  logic         src_vld,
    output logic [W-1:0] dly_data,
    output logic         dly_vld
);

    generate
        if (DELAY == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dly_data = src_data;
            assign dly_vld  = src_vld;
        end else begin : g_pipe
            logic [DELAY-1:0][W-1:0] data_p;
            logic [DELAY-1:0]        vld_p;

            always_ff @(posedge clk) begin
                data_p[0] <= src_data;
                for (int i = 1; i < DELAY; i++) begin
                    data_p[i] <= data_p[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_p <= '0;
                end else begin
                    vld_p[0] <= src_vld;
                    for (int i = 1; i < DELAY; i++) begin
                        vld_p[i] <= vld_p[i-1];
                    end
                end
            end

            assign dly_data = data_p[DELAY-1];
            assign dly_vld  = vld_p[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/a_skew_buffer.sv
// Activation FIFO feeding the systolic array A edge: streams rd_len vectors
// on command, skewing lane r by r cycles and zeroing invalid lane slots.
module a_skew_buffer
    import a_skew_buffer_pkg::*;
#(
    parameter int SYS_ROWS = sys_rows,
    parameter int A_BW     = A_BITWIDTH,
    parameter int DEPTH    = input_buffer_depth
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [SYS_ROWS*A_BW-1:0]   wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       rd_start,
    input  logic [$clog2(DEPTH):0]     rd_len,
    output logic                       start_err,
    output logic                       busy,
    output logic                       done,
    output logic [SYS_ROWS*A_BW-1:0]   a_out,
    output logic [SYS_ROWS-1:0]        a_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = (SYS_ROWS > 1) ? $clog2(SYS_ROWS) : 1;

    logic [SYS_ROWS*A_BW-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count_q;
    skew_state_t              state, state_next;
    logic [CW-1:0]            rem_q, rem_next;
    logic [FW-1:0]            flush_q, flush_next;
    logic                     done_q, done_next;
    logic                     start_err_q, start_err_next;
    logic                     push, pop, start_ok;

    logic [SYS_ROWS*A_BW-1:0] rd_data_p0;
    logic                     vld_p0;
    logic [A_BW-1:0]          lane_data [SYS_ROWS];

    assign push     = wr_en && !full;
    assign pop      = (state == STREAM);
    assign start_ok = (rd_len != '0) && (rd_len <= count_q);

    always_comb begin
        state_next     = state;
        rem_next       = rem_q;
        flush_next     = flush_q;
        done_next      = 1'b0;
        start_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start) begin
                    if (start_ok) begin
                        state_next = STREAM;
                        rem_next   = rd_len;
                    end else begin
                        start_err_next = 1'b1;
                    end
                end
            end
            STREAM: begin
                rem_next = rem_q - 1'b1;
                if (rem_q == CW'(1)) begin
                    state_next = FLUSH;
                    flush_next = '0;
                end
            end
            FLUSH: begin
                flush_next = flush_q + 1'b1;
                if (flush_q == FW'(SYS_ROWS - 1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem_q       <= '0;
            flush_q     <= '0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            vld_p0      <= 1'b0;
        end else begin
            state       <= state_next;
            rem_q       <= rem_next;
            flush_q     <= flush_next;
            done_q      <= done_next;
            start_err_q <= start_err_next;
            vld_p0      <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Stage p0: registered FIFO read feeding the per-lane skew lines
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
        if (pop)  rd_data_p0  <= mem[rd_ptr];
    end

    generate
        for (genvar r = 0; r < SYS_ROWS; r++) begin : g_lane
            skew_delay_line #(
                .DELAY (r),
                .W     (A_BW)
            ) u_dly (
                .clk      (clk),
                .rst_n    (rst_n),
                .src_data (rd_data_p0[r*A_BW +: A_BW]),
                .src_vld  (vld_p0),
                .dly_data (lane_data[r]),
                .dly_vld  (a_valid[r])
            );
            assign a_out[r*A_BW +: A_BW] = a_valid[r] ? lane_data[r] : '0;
        end
    endgenerate

    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign start_err = start_err_q;

endmodule
